// File: rtl/mmio_serial_hub_if.sv
// CPU-side MEM-stage bus bundle for the serial channel hub.
// Master drives the access and RAM data; slave returns rdata and is_io.
interface mmio_serial_hub_if;
    logic [1:0]  memRW;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] ram_rdata;
    logic [15:0] rdata;
    logic        is_io;

    modport master (
        output memRW, addr, wdata, ram_rdata,
        input  rdata, is_io
    );

    modport slave (
        input  memRW, addr, wdata, ram_rdata,
        output rdata, is_io
    );
endinterface

// File: rtl/mmio_serial_hub.sv
// MMIO decoder with per-channel RX FIFOs and TX holding registers.
// Optional rx-interrupt logic is enabled by defining MMIO_SERIAL_IRQ_EN.
module mmio_serial_hub #(
    parameter int          NUM_CH     = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BASE_ADDR  = 16'hBF00
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_serial_hub_if.slave      bus,
    input  logic [NUM_CH-1:0]     rx_valid,
    input  logic [8*NUM_CH-1:0]   rx_byte,
    output logic [NUM_CH-1:0]     tx_valid,
    output logic [8*NUM_CH-1:0]   tx_byte,
    input  logic [NUM_CH-1:0]     tx_ready
`ifdef MMIO_SERIAL_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [15:0] WIN = 16'(2 * NUM_CH);

    logic [15:0] off;
    logic        in_win;
    logic        is_stat;
    logic [2:0]  ch;
    logic        rd;
    logic        wr;

    // Unsigned wrap makes addresses below BASE_ADDR land far outside WIN.
    assign off     = bus.addr - BASE_ADDR;
    assign in_win  = off < WIN;
    assign is_stat = off[0];
    assign ch      = off[3:1];
    assign rd      = in_win && (bus.memRW == 2'b01);
    assign wr      = in_win && (bus.memRW == 2'b10);
    assign bus.is_io = in_win;

    logic [NUM_CH-1:0]      sel;
    logic [NUM_CH-1:0]      nonempty;
    logic [NUM_CH-1:0]      ovf;
    logic [NUM_CH-1:0]      unf;
    logic [NUM_CH-1:0]      txovr;
    logic [NUM_CH-1:0]      rxie;
    logic [NUM_CH-1:0][7:0] head;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [AW-1:0]   wp_q, wp_d;
        logic [AW-1:0]   rp_q, rp_d;
        logic [CNTW-1:0] cnt_q, cnt_d;
        logic            ovf_q, ovf_d;
        logic            unf_q, unf_d;
        logic            txovr_q, txovr_d;
        logic            tv_q, tv_d;
        logic [7:0]      tb_q, tb_d;
        logic [7:0]      mem_q [FIFO_DEPTH];
        logic            drd, srd, dwr;
        logic            empty, full, pop, push;
        logic            xfer, load;

        assign sel[c] = (ch == 3'(c));

        always_comb begin
            drd   = rd & sel[c] & ~is_stat;
            srd   = rd & sel[c] & is_stat;
            dwr   = wr & sel[c] & ~is_stat;
            empty = (cnt_q == '0);
            full  = (cnt_q == CNTW'(FIFO_DEPTH));
            pop   = drd & ~empty;
            push  = rx_valid[c] & (~full | pop);
            xfer  = tv_q & tx_ready[c];
            load  = dwr & (~tv_q | tx_ready[c]);

            wp_d  = push ? wp_q + 1'b1 : wp_q;
            rp_d  = pop ? rp_q + 1'b1 : rp_q;
            cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);

            // Setting events take priority over the status-read clear.
            ovf_d   = (rx_valid[c] & full & ~pop) | (ovf_q & ~srd);
            unf_d   = (drd & empty) | (unf_q & ~srd);
            txovr_d = (dwr & tv_q & ~tx_ready[c]) | (txovr_q & ~srd);

            tv_d = load | (tv_q & ~xfer);
            tb_d = load ? bus.wdata[7:0] : tb_q;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wp_q    <= '0;
                rp_q    <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
                txovr_q <= 1'b0;
                tv_q    <= 1'b0;
                tb_q    <= '0;
            end else begin
                wp_q    <= wp_d;
                rp_q    <= rp_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
                unf_q   <= unf_d;
                txovr_q <= txovr_d;
                tv_q    <= tv_d;
                tb_q    <= tb_d;
            end
        end

        // Storage needs no reset: entries are only visible via count.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wp_q] <= rx_byte[8*c +: 8];
            end
        end

        assign head[c]          = mem_q[rp_q];
        assign nonempty[c]      = ~empty;
        assign ovf[c]           = ovf_q;
        assign unf[c]           = unf_q;
        assign txovr[c]         = txovr_q;
        assign tx_valid[c]      = tv_q;
        assign tx_byte[8*c +: 8] = tb_q;

`ifdef MMIO_SERIAL_IRQ_EN
        logic swr;
        logic rxie_q, rxie_d;

        always_comb begin
            swr    = wr & sel[c] & is_stat;
            rxie_d = swr ? bus.wdata[8] : rxie_q;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rxie_q <= 1'b0;
            end else begin
                rxie_q <= rxie_d;
            end
        end

        assign rxie[c] = rxie_q;
`else
        assign rxie[c] = 1'b0;
`endif
    end

    logic [15:0] rdata_c;

    always_comb begin
        rdata_c = bus.ram_rdata;
        if (in_win) begin
            rdata_c = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel[c]) begin
                    if (is_stat) begin
                        rdata_c = {7'b0, rxie[c], 3'b0, ovf[c], unf[c],
                                   txovr[c], nonempty[c], ~tx_valid[c]};
                    end else begin
                        rdata_c = {8'h00, nonempty[c] ? head[c] : 8'h00};
                    end
                end
            end
        end
    end

    assign bus.rdata = rdata_c;

`ifdef MMIO_SERIAL_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = |(rxie & nonempty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_mmio_serial_hub.sv
// Directed bench for mmio_serial_hub (NUM_CH=2, FIFO_DEPTH=8).
// Covers decode, FIFO, flags, TX handshake, async reset and optional irq.
module tb_mmio_serial_hub;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rx_valid;
    logic [15:0] rx_byte;
    logic [1:0]  tx_valid;
    logic [15:0] tx_byte;
    logic [1:0]  tx_ready;
`ifdef MMIO_SERIAL_IRQ_EN
    logic        irq;
`endif
    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    mmio_serial_hub_if bus ();

    mmio_serial_hub #(
        .NUM_CH    (2),
        .FIFO_DEPTH(8),
        .BASE_ADDR (16'hBF00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .tx_valid(tx_valid),
        .tx_byte (tx_byte),
        .tx_ready(tx_ready)
`ifdef MMIO_SERIAL_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                      input string tag);
        bus.memRW = 2'b01;
        bus.addr  = a;
        #1;
        chk(tag, bus.rdata, exp);
        step();
        bus.memRW = 2'b00;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.memRW = 2'b10;
        bus.addr  = a;
        bus.wdata = d;
        step();
        bus.memRW = 2'b00;
    endtask

    task automatic push(input int c, input logic [7:0] b);
        rx_valid[c]        = 1'b1;
        rx_byte[8*c +: 8]  = b;
        step();
        rx_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        bus.memRW     = 2'b00;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.ram_rdata = 16'hBEEF;
        rx_valid      = '0;
        rx_byte       = '0;
        tx_ready      = '0;

        #12;
        chk("reset tx_valid", {14'b0, tx_valid}, 16'h0000);
        chk("reset tx_byte", tx_byte, 16'h0000);
        rst = 1'b1;
        step();

        // RAM pass-through and idle status
        bus.memRW = 2'b01;
        bus.addr  = 16'h1234;
        #1;
        chk("ram rdata", bus.rdata, 16'hBEEF);
        chk("ram is_io", {15'b0, bus.is_io}, 16'h0000);
        step();
        bus.memRW = 2'b00;
        bus.addr  = 16'hBF01;
        #1;
        chk("win is_io", {15'b0, bus.is_io}, 16'h0001);
        rd(16'hBF01, 16'h0001, "idle status ch0");

        // ch0 FIFO order and underrun
        push(0, 8'h41);
        push(0, 8'h42);
        rd(16'hBF00, 16'h0041, "ch0 data 1");
        rd(16'hBF00, 16'h0042, "ch0 data 2");
        rd(16'hBF01, 16'h0001, "ch0 drained status");
        rd(16'hBF00, 16'h0000, "ch0 empty data");
        rd(16'hBF01, 16'h0009, "ch0 unf status");
        rd(16'hBF01, 16'h0001, "ch0 unf cleared");

        // ch1 overflow
        for (int i = 0; i < 9; i++) begin
            push(1, 8'(8'h10 + i));
        end
        rd(16'hBF03, 16'h0013, "ch1 ovf status");
        rd(16'hBF03, 16'h0003, "ch1 ovf cleared");

        // full FIFO: push and pop in the same cycle
        bus.memRW     = 2'b01;
        bus.addr      = 16'hBF02;
        rx_valid[1]   = 1'b1;
        rx_byte[15:8] = 8'h99;
        #1;
        chk("full pop+push data", bus.rdata, 16'h0010);
        step();
        bus.memRW = 2'b00;
        rx_valid  = '0;
        rd(16'hBF03, 16'h0003, "full pop+push no ovf");
        for (int i = 0; i < 7; i++) begin
            rd(16'hBF02, 16'(16'h0011 + i), "ch1 drain");
        end
        rd(16'hBF02, 16'h0099, "ch1 drain last");
        rd(16'hBF02, 16'h0000, "ch1 empty after 8");
        rd(16'hBF03, 16'h0009, "ch1 unf status");

        // TX hold and overrun
        wr(16'hBF02, 16'h0055);
        chk("tx valid after load", {14'b0, tx_valid}, 16'h0002);
        chk("tx byte after load", tx_byte, 16'h5500);
        wr(16'hBF02, 16'h0066);
        chk("tx byte held", tx_byte, 16'h5500);
        rd(16'hBF03, 16'h0004, "ch1 txovr status");
        rd(16'hBF03, 16'h0000, "ch1 txovr cleared");
        tx_ready = 2'b10;
        #1;
        chk("tx valid before xfer", {14'b0, tx_valid}, 16'h0002);
        step();
        tx_ready = 2'b00;
        chk("tx valid after xfer", {14'b0, tx_valid}, 16'h0000);

        // reload in the transfer cycle
        wr(16'hBF02, 16'h0077);
        chk("tx byte 77", tx_byte, 16'h7700);
        tx_ready = 2'b10;
        wr(16'hBF02, 16'h0088);
        tx_ready = 2'b00;
        chk("tx valid reload", {14'b0, tx_valid}, 16'h0002);
        chk("tx byte reload", tx_byte, 16'h8800);
        rd(16'hBF03, 16'h0000, "reload no txovr");
        tx_ready = 2'b10;
        step();
        tx_ready = 2'b00;
        chk("tx valid final", {14'b0, tx_valid}, 16'h0000);

        // async reset mid-stream
        push(0, 8'hA1);
        push(0, 8'hA2);
        push(0, 8'hA3);
        wr(16'hBF00, 16'h005A);
        chk("ch0 tx before rst", {14'b0, tx_valid}, 16'h0001);
        rd(16'hBF02, 16'h0000, "ch1 unf before rst");
        #2;
        rst = 1'b0;
        #1;
        chk("rst tx_valid", {14'b0, tx_valid}, 16'h0000);
        chk("rst tx_byte", tx_byte, 16'h0000);
        bus.memRW = 2'b01;
        bus.addr  = 16'hBF01;
        #1;
        chk("rst ch0 status", bus.rdata, 16'h0001);
        bus.addr = 16'hBF00;
        #1;
        chk("rst ch0 data", bus.rdata, 16'h0000);
        bus.addr = 16'hBF03;
        #1;
        chk("rst ch1 status", bus.rdata, 16'h0001);
        bus.memRW = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        step();
        rd(16'hBF00, 16'h0000, "post rst data");
        rd(16'hBF01, 16'h0009, "post rst unf");

`ifdef MMIO_SERIAL_IRQ_EN
        wr(16'hBF01, 16'h0100);
        rd(16'hBF01, 16'h0101, "rxie status");
        chk("irq idle", {15'b0, irq}, 16'h0000);
        push(0, 8'hC3);
        chk("irq latency", {15'b0, irq}, 16'h0000);
        step();
        chk("irq set", {15'b0, irq}, 16'h0001);
        rd(16'hBF00, 16'h00C3, "irq data pop");
        chk("irq after pop edge", {15'b0, irq}, 16'h0001);
        step();
        chk("irq cleared", {15'b0, irq}, 16'h0000);
`else
        wr(16'hBF01, 16'h0100);
        rd(16'hBF01, 16'h0001, "status write ignored");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
